// File: rtl/wb_master_bridge.sv
// Wishbone classic-cycle initiator: one cyc/stb cycle per accepted command,
// returning read data or a timeout error on a valid/ready response port.
module wb_master_bridge #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_dat_o,
  output logic                    rsp_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  cmd_ready_q, cmd_ready_d;

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q gates acceptance so nothing is taken before the
        // first edge after reset release.
        if (cmd_ready_q && cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wb_ack_i) begin
          rsp_dat_d = we_q ? '0 : wb_dat_i;
          rsp_err_d = 1'b0;
          cyc_d     = 1'b0;
          state_d   = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          cyc_d     = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered from the next state so every output
    // comes straight from a flop.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: a vector table run through a small
// memory-backed Wishbone slave, plus backpressure, spurious-ack and reset cases.
module tb_wb_master_bridge;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          wb_cyc, wb_stb, wb_we, wb_ack;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack)
  );

  // Slave: acks in the ack_delay-th cycle of stb (0 = never), 16-word memory.
  logic [DW-1:0] mem [16];
  int            ack_delay = 0;
  int            stb_cnt = 0;
  logic          force_ack = 1'b0;
  logic [DW-1:0] force_dat = '0;

  assign wb_ack   = force_ack | (wb_stb && (ack_delay != 0) && (stb_cnt == ack_delay - 1));
  assign wb_dat_i = force_ack ? force_dat : (wb_we ? '0 : mem[wb_adr[5:2]]);

  always @(posedge clk) begin
    stb_cnt <= wb_stb ? stb_cnt + 1 : 0;
    if (wb_ack && wb_stb && wb_we)
      for (int b = 0; b < 4; b++)
        if (wb_sel[b]) mem[wb_adr[5:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    int            ack_delay;
    logic [DW-1:0] exp_dat;
    logic          exp_err;
    int            exp_stb;
  } vec_t;

  // Issue one command, check the bus cycle and response, then complete the handshake.
  task automatic run_cmd(input vec_t v, input string tag);
    bit accepted = 0, done = 0, first = 1;
    int stb_n = 0;
    ack_delay = v.ack_delay;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin accepted = 1; break; end
      @(negedge clk);
    end
    check({tag, " accepted"}, 64'(accepted), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wb_stb) begin
        if (first) begin
          check({tag, " wb_cyc"}, 64'(wb_cyc), 64'd1);
          check({tag, " wb_we"},  64'(wb_we),  64'(v.we));
          check({tag, " wb_adr"}, 64'(wb_adr), 64'(v.adr));
          check({tag, " wb_sel"}, 64'(wb_sel), 64'(v.sel));
          check({tag, " cmd_ready busy"}, 64'(cmd_ready), 64'd0);
          if (v.we) check({tag, " wb_dat"}, 64'(wb_dat_o), 64'(v.dat));
        end
        first = 0;
        stb_n++;
      end
      if (rsp_valid) begin done = 1; break; end
      @(negedge clk);
    end
    check({tag, " rsp_valid seen"}, 64'(done), 64'd1);
    check({tag, " stb cycles"}, 64'(stb_n), 64'(v.exp_stb));
    check({tag, " cyc low in resp"}, 64'(wb_cyc), 64'd0);
    check({tag, " rsp_dat"}, 64'(rsp_dat), 64'(v.exp_dat));
    check({tag, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " ready after rsp"}, 64'(cmd_ready), 64'd1);
    check({tag, " rsp_valid cleared"}, 64'(rsp_valid), 64'd0);
  endtask

  vec_t vecs [7];
  vec_t v;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    //          we    adr       dat           sel   dly exp_dat       err  stb
    vecs[0] = '{1'b1, 20'h10, 32'hDEADBEEF, 4'hF, 2, 32'h0,        1'b0, 2};
    vecs[1] = '{1'b0, 20'h10, 32'h0,        4'hF, 1, 32'hDEADBEEF, 1'b0, 1};
    vecs[2] = '{1'b1, 20'h14, 32'h11223344, 4'h5, 3, 32'h0,        1'b0, 3};
    vecs[3] = '{1'b0, 20'h14, 32'h0,        4'hF, 8, 32'h00220044, 1'b0, 8};
    vecs[4] = '{1'b0, 20'h10, 32'h0,        4'hF, 0, 32'h0,        1'b1, 8};
    vecs[5] = '{1'b1, 20'h18, 32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b1, 8};
    vecs[6] = '{1'b0, 20'h18, 32'h0,        4'hF, 7, 32'h0,        1'b0, 7};

    // Reset values while rst_n is low.
    #12;
    check("reset cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset cyc", 64'(wb_cyc), 64'd0);
    check("reset stb", 64'(wb_stb), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_dat", 64'(rsp_dat), 64'd0);
    check("reset rsp_err", 64'(rsp_err), 64'd0);
    check("reset wb_adr", 64'(wb_adr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held 5 cycles while a new command waits.
    v = '{1'b0, 20'h10, 32'h0, 4'hF, 1, 32'hDEADBEEF, 1'b0, 1};
    ack_delay = 1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 20'h10; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_adr = 20'h14;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    check("bp rsp_valid", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp no cyc", 64'(wb_cyc), 64'd0);
      check("bp rsp_dat", 64'(rsp_dat), 64'hDEADBEEF);
      check("bp rsp_valid held", 64'(rsp_valid), 64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("bp ready after handshake", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    check("bp no new cyc", 64'(wb_cyc), 64'd0);

    // Spurious ack in IDLE must be ignored.
    force_ack = 1'b1; force_dat = 32'h1234;
    @(negedge clk);
    @(negedge clk);
    force_ack = 1'b0;
    check("spur rsp_valid", 64'(rsp_valid), 64'd0);
    check("spur cyc", 64'(wb_cyc), 64'd0);
    check("spur cmd_ready", 64'(cmd_ready), 64'd1);
    run_cmd('{1'b0, 20'h10, 32'h0, 4'hF, 2, 32'hDEADBEEF, 1'b0, 2}, "spur read");

    // Reset in the middle of a bus cycle.
    ack_delay = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 20'h14;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid stb before reset", 64'(wb_stb), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset cyc", 64'(wb_cyc), 64'd0);
    check("mid reset stb", 64'(wb_stb), 64'd0);
    check("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid reset cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd('{1'b0, 20'h14, 32'h0, 4'hF, 2, 32'h00220044, 1'b0, 2}, "post reset read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
